// File: rtl/zap_mult_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the multiply issue sequencer: multiply micro-op
// opcodes (the values zap_multiply decodes) and the sequencer state type.
package zap_mult_sequencer_pkg;

    // Multiply micro-op opcodes understood by zap_multiply.
    localparam int UMLALL  = 16;
    localparam int UMLALH  = 17;
    localparam int SMLALL  = 18;
    localparam int SMLALH  = 19;
    // Any opcode outside the four above leaves zap_multiply idle.
    localparam int MUL_NOP = 31;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_L = 2'd1,
        ST_RUN_H = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/zap_mult_sequencer.sv
`timescale 1ns/1ps
// Issue-side sequencer for zap_multiply. Accepts one multiply instruction,
// drives the low-half micro-op and, for 64-bit forms, the high-half micro-op,
// holding operands stable while zap_multiply is busy. Returns one writeback
// pulse per result half plus N/Z flags with the final half.
module zap_mult_sequencer
    import zap_mult_sequencer_pkg::*;
#(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
)(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear_from_writeback,
    input  logic                        i_data_stall,
    input  logic                        i_clear_from_alu,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_long,
    input  logic                        i_signed,
    input  logic                        i_accumulate,
    input  logic                        i_set_flags,
    input  logic [31:0]                 i_rm,
    input  logic [31:0]                 i_rs,
    input  logic [31:0]                 i_rn,
    input  logic [31:0]                 i_rh,
    input  logic [$clog2(PHY_REGS)-1:0] i_rd_lo,
    input  logic [$clog2(PHY_REGS)-1:0] i_rd_hi,
    output logic [$clog2(ALU_OPS)-1:0]  o_alu_operation,
    output logic                        o_cc_satisfied,
    output logic [31:0]                 o_rm,
    output logic [31:0]                 o_rs,
    output logic [31:0]                 o_rn,
    output logic [31:0]                 o_rh,
    input  logic                        i_mul_busy,
    input  logic                        i_mul_nozero,
    input  logic [31:0]                 i_mul_rd,
    output logic                        o_wb_valid,
    output logic [$clog2(PHY_REGS)-1:0] o_wb_index,
    output logic [31:0]                 o_wb_data,
    output logic                        o_flags_valid,
    output logic                        o_flag_n,
    output logic                        o_flag_z
);

    localparam int IDX_W = $clog2(PHY_REGS);
    localparam int OP_W  = $clog2(ALU_OPS);

    localparam logic [OP_W-1:0] OP_UMLALL = OP_W'(UMLALL);
    localparam logic [OP_W-1:0] OP_UMLALH = OP_W'(UMLALH);
    localparam logic [OP_W-1:0] OP_SMLALL = OP_W'(SMLALL);
    localparam logic [OP_W-1:0] OP_SMLALH = OP_W'(SMLALH);
    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(MUL_NOP);

    // N/Z for the full result. For the 64-bit form the low half is only
    // visible through zap_multiply's nozero indication, so Z needs both.
    function automatic logic [1:0] calc_flags(input logic is_long,
                                              input logic [31:0] rd,
                                              input logic nozero);
        logic n;
        logic z;
        n = rd[31];
        z = (rd == 32'd0) && !(is_long && nozero);
        return {n, z};
    endfunction

    // Sequencer state and latched instruction.
    seq_state_t        r_state;
    logic              r_first_cycle;
    logic              r_long;
    logic              r_signed;
    logic              r_set_flags;
    logic [IDX_W-1:0]  r_rd_lo;
    logic [IDX_W-1:0]  r_rd_hi;
    logic [31:0]       r_rm;
    logic [31:0]       r_rs;
    logic [31:0]       r_rn;
    logic [31:0]       r_rh;

    // Registered outputs.
    logic              r_ready;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_cc;
    logic              r_wb_valid;
    logic [IDX_W-1:0]  r_wb_index;
    logic [31:0]       r_wb_data;
    logic              r_flags_valid;
    logic              r_flag_n;
    logic              r_flag_z;

    // Next-state values.
    seq_state_t        w_state_next;
    logic              w_first_next;
    logic              w_accept;
    logic              w_sel_signed;
    logic              w_ready_next;
    logic [OP_W-1:0]   w_alu_op_next;
    logic              w_cc_next;
    logic              w_wb_valid_next;
    logic [IDX_W-1:0]  w_wb_index_next;
    logic [31:0]       w_wb_data_next;
    logic              w_flags_valid_next;
    logic              w_flag_n_next;
    logic              w_flag_z_next;
    logic [1:0]        w_flags;

    // Next-state and next-output decode: writeback flush, then stall, then ALU flush.
    always_comb begin
        w_state_next       = r_state;
        w_first_next       = r_first_cycle;
        w_accept           = 1'b0;
        w_wb_valid_next    = 1'b0;
        w_wb_index_next    = r_wb_index;
        w_wb_data_next     = r_wb_data;
        w_flags_valid_next = 1'b0;
        w_flag_n_next      = r_flag_n;
        w_flag_z_next      = r_flag_z;
        w_flags            = 2'b00;

        if (i_clear_from_writeback) begin
            w_state_next = ST_IDLE;
            w_first_next = 1'b0;
        end else if (i_data_stall) begin
            // Frozen: a pulse already on the outputs stays there unchanged.
            w_wb_valid_next    = r_wb_valid;
            w_flags_valid_next = r_flags_valid;
        end else if (i_clear_from_alu) begin
            w_state_next = ST_IDLE;
            w_first_next = 1'b0;
        end else begin
            w_first_next = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_RUN_L;
                        w_first_next = 1'b1;
                    end
                end
                ST_RUN_L: begin
                    // zap_multiply only reacts to the opcode one cycle after it
                    // appears, so busy is meaningless in the first cycle.
                    if (!r_first_cycle && !i_mul_busy) begin
                        w_wb_valid_next = 1'b1;
                        w_wb_index_next = r_rd_lo;
                        w_wb_data_next  = i_mul_rd;
                        if (r_long) begin
                            w_state_next = ST_RUN_H;
                            w_first_next = 1'b1;
                        end else begin
                            w_state_next = ST_DONE;
                            w_flags      = calc_flags(1'b0, i_mul_rd, i_mul_nozero);
                            if (r_set_flags) begin
                                w_flags_valid_next = 1'b1;
                                w_flag_n_next      = w_flags[1];
                                w_flag_z_next      = w_flags[0];
                            end
                        end
                    end
                end
                ST_RUN_H: begin
                    if (!r_first_cycle && !i_mul_busy) begin
                        w_wb_valid_next = 1'b1;
                        w_wb_index_next = r_rd_hi;
                        w_wb_data_next  = i_mul_rd;
                        w_state_next    = ST_DONE;
                        w_flags         = calc_flags(1'b1, i_mul_rd, i_mul_nozero);
                        if (r_set_flags) begin
                            w_flags_valid_next = 1'b1;
                            w_flag_n_next      = w_flags[1];
                            w_flag_z_next      = w_flags[0];
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Outputs follow the state being entered, so they are registered
        // together with it and change on the same edge.
        w_sel_signed = w_accept ? (i_signed && i_long) : r_signed;
        w_ready_next = (w_state_next == ST_IDLE);
        case (w_state_next)
            ST_RUN_L: begin
                w_alu_op_next = w_sel_signed ? OP_SMLALL : OP_UMLALL;
                w_cc_next     = 1'b1;
            end
            ST_RUN_H: begin
                w_alu_op_next = w_sel_signed ? OP_SMLALH : OP_UMLALH;
                w_cc_next     = 1'b1;
            end
            default: begin
                w_alu_op_next = OP_NOP;
                w_cc_next     = 1'b0;
            end
        endcase
    end

    // State register with the first-cycle busy mask.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_first_cycle <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_first_cycle <= w_first_next;
        end
    end

    // Latch the instruction on accept; accumulators not in use are zeroed here
    // so zap_multiply always sees a plain {rh,rn} + rm*rs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_long      <= 1'b0;
            r_signed    <= 1'b0;
            r_set_flags <= 1'b0;
            r_rd_lo     <= '0;
            r_rd_hi     <= '0;
            r_rm        <= '0;
            r_rs        <= '0;
            r_rn        <= '0;
            r_rh        <= '0;
        end else if (w_accept) begin
            r_long      <= i_long;
            r_signed    <= i_signed && i_long;
            r_set_flags <= i_set_flags;
            r_rd_lo     <= i_rd_lo;
            r_rd_hi     <= i_rd_hi;
            r_rm        <= i_rm;
            r_rs        <= i_rs;
            r_rn        <= i_accumulate ? i_rn : 32'd0;
            r_rh        <= (i_accumulate && i_long) ? i_rh : 32'd0;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready       <= 1'b1;
            r_alu_op      <= OP_NOP;
            r_cc          <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_index    <= '0;
            r_wb_data     <= '0;
            r_flags_valid <= 1'b0;
            r_flag_n      <= 1'b0;
            r_flag_z      <= 1'b0;
        end else begin
            r_ready       <= w_ready_next;
            r_alu_op      <= w_alu_op_next;
            r_cc          <= w_cc_next;
            r_wb_valid    <= w_wb_valid_next;
            r_wb_index    <= w_wb_index_next;
            r_wb_data     <= w_wb_data_next;
            r_flags_valid <= w_flags_valid_next;
            r_flag_n      <= w_flag_n_next;
            r_flag_z      <= w_flag_z_next;
        end
    end

    assign o_ready         = r_ready;
    assign o_alu_operation = r_alu_op;
    assign o_cc_satisfied  = r_cc;
    assign o_rm            = r_rm;
    assign o_rs            = r_rs;
    assign o_rn            = r_rn;
    assign o_rh            = r_rh;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_index      = r_wb_index;
    assign o_wb_data       = r_wb_data;
    assign o_flags_valid   = r_flags_valid;
    assign o_flag_n        = r_flag_n;
    assign o_flag_z        = r_flag_z;

endmodule

// File: tb/tb_zap_mult_sequencer.sv
`timescale 1ns/1ps
// Bench for zap_mult_sequencer: a cycle-level stand-in for zap_multiply sits
// beside the DUT, stimulus pushes expected writebacks into a scoreboard and a
// monitor pops and compares each writeback pulse.
module tb_zap_mult_sequencer;
    import zap_mult_sequencer_pkg::*;

    localparam logic [4:0] OP_UL  = 5'(UMLALL);
    localparam logic [4:0] OP_UH  = 5'(UMLALH);
    localparam logic [4:0] OP_SL  = 5'(SMLALL);
    localparam logic [4:0] OP_SH  = 5'(SMLALH);
    localparam logic [4:0] OP_NOP = 5'(MUL_NOP);

    typedef struct {
        bit          lng;
        bit          sgn;
        bit          acc;
        bit          sf;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] rn;
        logic [31:0] rh;
        logic [5:0]  lo;
        logic [5:0]  hi;
    } txn_t;

    typedef struct {
        int          cyc;
        logic [5:0]  idx;
        logic [31:0] data;
        bit          fv;
        bit          n;
        bit          z;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear_from_writeback = 1'b0;
    logic        i_data_stall = 1'b0;
    logic        i_clear_from_alu = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_long = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_accumulate = 1'b0;
    logic        i_set_flags = 1'b0;
    logic [31:0] i_rm = '0;
    logic [31:0] i_rs = '0;
    logic [31:0] i_rn = '0;
    logic [31:0] i_rh = '0;
    logic [5:0]  i_rd_lo = '0;
    logic [5:0]  i_rd_hi = '0;
    logic        o_ready;
    logic [4:0]  o_alu_operation;
    logic        o_cc_satisfied;
    logic [31:0] o_rm;
    logic [31:0] o_rs;
    logic [31:0] o_rn;
    logic [31:0] o_rh;
    logic        i_mul_busy;
    logic        i_mul_nozero;
    logic [31:0] i_mul_rd;
    logic        o_wb_valid;
    logic [5:0]  o_wb_index;
    logic [31:0] o_wb_data;
    logic        o_flags_valid;
    logic        o_flag_n;
    logic        o_flag_z;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    zap_mult_sequencer #(.PHY_REGS(46), .ALU_OPS(32)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_valid                (i_valid),
        .o_ready                (o_ready),
        .i_long                 (i_long),
        .i_signed               (i_signed),
        .i_accumulate           (i_accumulate),
        .i_set_flags            (i_set_flags),
        .i_rm                   (i_rm),
        .i_rs                   (i_rs),
        .i_rn                   (i_rn),
        .i_rh                   (i_rh),
        .i_rd_lo                (i_rd_lo),
        .i_rd_hi                (i_rd_hi),
        .o_alu_operation        (o_alu_operation),
        .o_cc_satisfied         (o_cc_satisfied),
        .o_rm                   (o_rm),
        .o_rs                   (o_rs),
        .o_rn                   (o_rn),
        .o_rh                   (o_rh),
        .i_mul_busy             (i_mul_busy),
        .i_mul_nozero           (i_mul_nozero),
        .i_mul_rd               (i_mul_rd),
        .o_wb_valid             (o_wb_valid),
        .o_wb_index             (o_wb_index),
        .o_wb_data              (o_wb_data),
        .o_flags_valid          (o_flags_valid),
        .o_flag_n               (o_flag_n),
        .o_flag_z               (o_flag_z)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- zap_multiply stand-in ----------------
    // Idle until it sees an xxLALx op with cc satisfied, then busy for four
    // cycles and presents its result half on the fifth.
    int          m_cnt;
    logic        m_sgn;
    logic        m_is_h;
    logic        m_nozero;
    logic [63:0] m_full;

    always_comb begin
        if (m_sgn)
            m_full = 64'(longint'($signed(o_rm)) * longint'($signed(o_rs))) + {o_rh, o_rn};
        else
            m_full = ({32'd0, o_rm} * {32'd0, o_rs}) + {o_rh, o_rn};
    end

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_cnt    <= 0;
            m_sgn    <= 1'b0;
            m_is_h   <= 1'b0;
            m_nozero <= 1'b0;
        end else if (i_clear_from_writeback) begin
            m_cnt <= 0;
        end else if (i_data_stall) begin
            m_cnt <= m_cnt;
        end else if (i_clear_from_alu) begin
            m_cnt <= 0;
        end else if (m_cnt == 0) begin
            if (o_cc_satisfied && (o_alu_operation inside {OP_UL, OP_UH, OP_SL, OP_SH})) begin
                m_cnt  <= 1;
                m_sgn  <= (o_alu_operation == OP_SL) || (o_alu_operation == OP_SH);
                m_is_h <= (o_alu_operation == OP_UH) || (o_alu_operation == OP_SH);
            end
        end else if (m_cnt == 5) begin
            m_cnt <= 0;
            if (!m_is_h) m_nozero <= (m_full[31:0] != 32'd0);
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign i_mul_busy   = (m_cnt >= 1) && (m_cnt <= 4);
    assign i_mul_rd     = (m_cnt == 5) ? (m_is_h ? m_full[63:32] : m_full[31:0]) : 32'd0;
    assign i_mul_nozero = m_nozero;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the architectural result of the instruction, from its operands.
    task automatic push_expect(input txn_t t, input int acc, input int stall_len, input int abort_at);
        logic [63:0] addend;
        logic [63:0] full;
        exp_t        e;
        addend = !t.acc ? 64'd0 : (t.lng ? {t.rh, t.rn} : {32'd0, t.rn});
        if (t.lng && t.sgn)
            full = 64'(longint'($signed(t.rm)) * longint'($signed(t.rs))) + addend;
        else
            full = ({32'd0, t.rm} * {32'd0, t.rs}) + addend;
        if (abort_at < 0 || abort_at >= 7) begin
            e.cyc  = acc + 7;
            e.idx  = t.lo;
            e.data = full[31:0];
            e.fv   = t.sf && !t.lng;
            e.n    = full[31];
            e.z    = (full[31:0] == 32'd0);
            exp_q.push_back(e);
        end
        if (t.lng && abort_at < 0) begin
            e.cyc  = acc + 13 + stall_len;
            e.idx  = t.hi;
            e.data = full[63:32];
            e.fv   = t.sf;
            e.n    = full[63];
            e.z    = (full == 64'd0);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        #1;
        if (!i_reset) begin
            if (o_wb_valid && !i_data_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb actual idx=%0d data=%h required=no pulse (cycle %0d)",
                             o_wb_index, o_wb_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("wb cycle=%0d idx=%0d data=%h flags_valid=%0b n=%0b z=%0b",
                             cyc, o_wb_index, o_wb_data, o_flags_valid, o_flag_n, o_flag_z);
                    chk("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("wb_index", 64'(o_wb_index), 64'(mon_e.idx));
                    chk("wb_data", 64'(o_wb_data), 64'(mon_e.data));
                    chk("flags_valid", 64'(o_flags_valid), 64'(mon_e.fv));
                    if (mon_e.fv) begin
                        chk("flag_n", 64'(o_flag_n), 64'(mon_e.n));
                        chk("flag_z", 64'(o_flag_z), 64'(mon_e.z));
                    end
                end
            end else if (o_flags_valid && !o_wb_valid) begin
                checks++;
                errors++;
                $display("FAIL lone_flags actual=1 required=0 (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1 (cycle %0d)", cyc);
        end
    endtask

    // One instruction. Offsets are cycles after the accept cycle; stall_len
    // cycles of stall start at stall_at; clear_at/reset_at < 0 means unused.
    task automatic run_txn(input txn_t t, input int stall_at, input int stall_len,
                           input int clear_at, input bit clear_wb, input int reset_at);
        int         acc;
        int         exp_ready;
        int         abort_at;
        bit         done;
        logic [4:0] exp_op;
        wait_ready();
        i_long       = t.lng;
        i_signed     = t.sgn;
        i_accumulate = t.acc;
        i_set_flags  = t.sf;
        i_rm         = t.rm;
        i_rs         = t.rs;
        i_rn         = t.rn;
        i_rh         = t.rh;
        i_rd_lo      = t.lo;
        i_rd_hi      = t.hi;
        i_valid      = 1'b1;
        acc          = cyc;
        abort_at     = (clear_at >= 0) ? clear_at : reset_at;
        $display("txn cycle=%0d long=%0b signed=%0b acc=%0b S=%0b rm=%h rs=%h rn=%h rh=%h lo=%0d hi=%0d",
                 acc, t.lng, t.sgn, t.acc, t.sf, t.rm, t.rs, t.rn, t.rh, t.lo, t.hi);
        push_expect(t, acc, stall_len, abort_at);
        exp_ready = (t.lng ? 14 : 8) + stall_len;
        done      = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                i_valid = 1'b0;
                i_rm = $urandom; i_rs = $urandom; i_rn = $urandom; i_rh = $urandom;
                i_long = 1'($urandom); i_signed = 1'($urandom);
                i_accumulate = 1'($urandom); i_set_flags = 1'($urandom);
                i_rd_lo = 6'($urandom_range(45)); i_rd_hi = 6'($urandom_range(45));
                exp_op = (t.lng && t.sgn) ? OP_SL : OP_UL;
                chk("opcode_l", 64'(o_alu_operation), 64'(exp_op));
                chk("cc_run_l", 64'(o_cc_satisfied), 64'(1));
            end
            if (k == 3) begin
                chk("hold_rm", 64'(o_rm), 64'(t.rm));
                chk("hold_rs", 64'(o_rs), 64'(t.rs));
                chk("hold_rn", 64'(o_rn), 64'(t.acc ? t.rn : 32'd0));
                chk("hold_rh", 64'(o_rh), 64'((t.acc && t.lng) ? t.rh : 32'd0));
            end
            if (k == 7 && t.lng && abort_at < 0) begin
                exp_op = t.sgn ? OP_SH : OP_UH;
                chk("opcode_h", 64'(o_alu_operation), 64'(exp_op));
            end
            i_data_stall = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
            if (k == clear_at) begin
                if (clear_wb) i_clear_from_writeback = 1'b1;
                else          i_clear_from_alu = 1'b1;
            end
            if (clear_at >= 0 && k == clear_at + 1) begin
                i_clear_from_alu       = 1'b0;
                i_clear_from_writeback = 1'b0;
                chk("clear_ready", 64'(o_ready), 64'(1));
                chk("clear_opcode", 64'(o_alu_operation), 64'(OP_NOP));
                chk("clear_cc", 64'(o_cc_satisfied), 64'(0));
                chk("clear_wb_valid", 64'(o_wb_valid), 64'(0));
                done = 1'b1;
            end
            if (k == reset_at) begin
                #2 i_reset = 1'b1;
                #1;
                chk("areset_ready", 64'(o_ready), 64'(1));
                chk("areset_opcode", 64'(o_alu_operation), 64'(OP_NOP));
                chk("areset_cc", 64'(o_cc_satisfied), 64'(0));
                chk("areset_operands", {o_rm, o_rs} | {o_rn, o_rh}, 64'd0);
                chk("areset_wb", {26'd0, o_wb_valid, o_wb_index, o_wb_data}, 64'd0);
                chk("areset_flags", 64'({o_flags_valid, o_flag_n, o_flag_z}), 64'd0);
                @(negedge i_clk);
                i_reset = 1'b0;
                done = 1'b1;
            end
            if (!done && abort_at < 0 && o_ready) begin
                chk("ready_return", 64'(k), 64'(exp_ready));
                done = 1'b1;
            end
        end
        i_data_stall = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout actual=busy required=idle (cycle %0d)", cyc);
        end
    endtask

    function automatic txn_t mk(input bit lng, input bit sgn, input bit acc, input bit sf,
                                input logic [31:0] rm, input logic [31:0] rs,
                                input logic [31:0] rn, input logic [31:0] rh);
        txn_t t;
        t.lng = lng; t.sgn = sgn; t.acc = acc; t.sf = sf;
        t.rm = rm; t.rs = rs; t.rn = rn; t.rh = rh;
        t.lo = 6'($urandom_range(45));
        t.hi = 6'($urandom_range(45));
        return t;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        txn_t t;
        int   sa;
        int   sl;
        repeat (2) @(negedge i_clk);
        chk("reset_ready", 64'(o_ready), 64'(1));
        chk("reset_opcode", 64'(o_alu_operation), 64'(OP_NOP));
        chk("reset_cc", 64'(o_cc_satisfied), 64'(0));
        chk("reset_wb", {26'd0, o_wb_valid, o_wb_index, o_wb_data}, 64'd0);
        chk("reset_flags", 64'({o_flags_valid, o_flag_n, o_flag_z}), 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // UMULL all-ones
        run_txn(mk(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0), 0, 0, -1, 0, -1);
        // SMLAL -2*3 + 5
        run_txn(mk(1, 1, 1, 1, 32'hFFFF_FFFE, 32'd3, 32'd5, 32'd0), 0, 0, -1, 0, -1);
        // UMULL 2^16 * 2^16: zero high-half bits only in the low half
        run_txn(mk(1, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0), 0, 0, -1, 0, -1);
        // UMULL by zero
        run_txn(mk(1, 0, 0, 1, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0), 0, 0, -1, 0, -1);
        // MLA 7*6 - 42
        run_txn(mk(0, 0, 1, 1, 32'd7, 32'd6, 32'hFFFF_FFD6, 32'h5555_5555), 0, 0, -1, 0, -1);
        // three-cycle stall in the high half
        run_txn(mk(1, 1, 1, 1, 32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0010, 32'h0000_0001), 9, 3, -1, 0, -1);
        // ALU flush on the low-half completion cycle
        run_txn(mk(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0), 0, 0, 6, 0, -1);
        // writeback flush during the high half
        run_txn(mk(1, 0, 1, 1, 32'h1234_5678, 32'h0000_0100, 32'd1, 32'd2), 0, 0, 10, 1, -1);
        // asynchronous reset in the low half
        run_txn(mk(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h2, 32'd0, 32'd0), 0, 0, -1, 0, 3);
        // one more after reset to confirm recovery
        run_txn(mk(0, 1, 0, 1, 32'h8000_0000, 32'h1, 32'd0, 32'd0), 0, 0, -1, 0, -1);

        for (int i = 0; i < 40; i++) begin
            t = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   rand_opnd(), rand_opnd(), rand_opnd(), rand_opnd());
            sa = 0;
            sl = 0;
            if (t.lng && ($urandom_range(3) == 0)) begin
                sa = $urandom_range(8, 10);
                sl = $urandom_range(1, 3);
            end
            run_txn(t, sa, sl, -1, 0, -1);
        end

        repeat (20) @(negedge i_clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
